// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter onto a single-ported RAM
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ready,
  output logic        err
);

  localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] BAD_LOAD = 32'hBAD1BAD1;

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t        state, next_state;
  logic [31:0]   lat_addr, lat_store;
  logic          lat_wr;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tcnt;
  logic          aband_q;

  logic dreq, forced, grant_d, grant_i, busy, owner_req, timeout, done, release_ok;

  assign dreq      = dREN | dWEN;
  assign ram_addr  = lat_addr;
  assign ram_store = lat_store;

  always_comb begin
    forced     = (starve_cnt == SW'(STARVE_MAX)) && iREN;
    grant_d    = (state == IDLE) && dreq && !forced;
    grant_i    = (state == IDLE) && iREN && !grant_d;
    busy       = (state != IDLE);
    owner_req  = (state == IBUSY) ? iREN : dreq;
    timeout    = busy && !ram_ready && (tcnt == TW'(TIMEOUT - 1));
    done       = busy && (ram_ready || timeout);
    // a requester that let go during the transaction is never completed, even if it re-asserts
    release_ok = done && owner_req && !aband_q;
  end

  always_comb begin
    next_state = state;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;
    iwait      = iREN;
    dwait      = dreq;
    iload      = 32'h0;
    dload      = 32'h0;
    case (state)
      IDLE: begin
        if (grant_d)      next_state = DBUSY;
        else if (grant_i) next_state = IBUSY;
      end
      IBUSY: begin
        ram_ren = 1'b1;
        if (done) next_state = IDLE;
        if (release_ok) begin
          iwait = 1'b0;
          iload = timeout ? BAD_LOAD : ram_load;
        end
      end
      DBUSY: begin
        ram_ren = !lat_wr;
        ram_wen = lat_wr;
        if (done) next_state = IDLE;
        if (release_ok) begin
          dwait = 1'b0;
          dload = timeout ? BAD_LOAD : (lat_wr ? 32'h0 : ram_load);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      lat_addr   <= 32'h0;
      lat_store  <= 32'h0;
      lat_wr     <= 1'b0;
      starve_cnt <= '0;
      tcnt       <= '0;
      aband_q    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_d || grant_i) begin
        lat_addr  <= grant_d ? daddr : iaddr;
        lat_store <= dstore;
        lat_wr    <= grant_d && dWEN;
        tcnt      <= '0;
        aband_q   <= 1'b0;
        if (grant_d && iREN) begin
          if (starve_cnt < SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
        end else begin
          starve_cnt <= '0;
        end
      end else if (busy) begin
        tcnt <= tcnt + TW'(1);
        if (!owner_req) aband_q <= 1'b1;
        if (timeout)    err     <= 1'b1;
      end
    end
  end

endmodule
